mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-fetch cache (I side) and the data cache (D side).
- Sits between both caches' memory-miss interfaces and the main memory model.
- Serialises one outstanding memory transaction at a time.
- Round-robin arbitration on contention; a per-transaction timeout reports a hung memory.

Parameters:
ADDR_W, 32, address width of requester and memory ports
DATA_W, 32, data word width
TIMEOUT, 255, max cycles in ISSUE awaiting mem_ready before error; 0 disables timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
i_rd  in  1  I-side read request
i_addr  in  ADDR_W  I-side address, stable while i_rd high
i_ack  out  1  one-cycle completion pulse to I side
i_rdata  out  DATA_W  I-side read data, valid when i_ack high
d_rd  in  1  D-side read request
d_wr  in  1  D-side write request
d_addr  in  ADDR_W  D-side address, stable while request high
d_wdata  in  DATA_W  D-side write data, stable while d_wr high
d_ack  out  1  one-cycle completion pulse to D side
d_rdata  out  DATA_W  D-side read data, valid when d_ack high
mem_oe  out  1  memory read strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, sampled only in ISSUE
busy  out  1  high whenever state != IDLE
err  out  1  one-cycle pulse coincident with ack of a timed-out transaction

Behaviour:
- States: IDLE, ISSUE, RESP. All outputs registered.
- Reset values: state IDLE, all acks/strobes/err/busy 0, mem_addr/mem_wdata/rdata regs 0, counter 0, last_grant = I, so the first tie goes to D.
- IDLE:
  - Sample requests.
  - D pending = d_rd|d_wr; I pending = i_rd.
  - Only one pending: grant it.
  - Both pending: grant the side not equal to last_grant.
  - On grant: latch addr, wdata and op into mem_* regs; set last_grant; clear counter; go to ISSUE.
  - No request: stay in IDLE.
- d_rd and d_wr both high: treated as write. mem_we=1, mem_oe=0.
- ISSUE:
  - Exactly one of mem_oe/mem_we is held high. mem_addr/mem_wdata are held constant.
  - mem_ready=1: capture mem_rdata into the granted side's rdata reg (write: rdata unchanged), drop strobes, go to RESP.
  - Else: counter increments.
  - TIMEOUT!=0 and counter==TIMEOUT-1 with no ready: drop strobes, set err flag, rdata of granted side = 0, go to RESP.
  - mem_ready in the same cycle as timeout expiry: ready wins, no err.
- RESP:
  - Granted side's ack=1 for exactly this cycle; err=1 if flagged. Next state IDLE unconditionally.
  - Requests are not sampled in RESP. The requester drops its request in the ack cycle; a request still high in the following IDLE cycle is a new transaction.
- Latency: request high at edge N. ISSUE from N+1. With mem_ready in the first ISSUE cycle, ack is at cycle N+2 (minimum). Back-to-back throughput is one transaction per 3 cycles minimum.
- Ungranted requester waits, holding its request. Round-robin bounds the wait to one foreign transaction.
- rdata regs hold their value between acks.
- Reset asserted mid-ISSUE/RESP: strobes and ack drop asynchronously; no ack is issued for the aborted transaction; last_grant returns to I.
- mem_ready outside ISSUE: ignored.

Test Plan:
- Single I read: i_rd=1, i_addr=0x100; memory returns 0xDEADBEEF with ready one cycle after mem_oe. Required: mem_oe high 1 cycle with mem_addr=0x100; i_ack pulse at request edge+2; i_rdata=0xDEADBEEF; busy high 2 cycles.
- Simultaneous after reset: i_rd and d_rd both high, addrs 0x10/0x20. Required: D served first (mem_addr=0x20), then I (0x10). Next tie grants D again only after I was served. d_ack precedes i_ack by 3 cycles.
- D write with 5-cycle memory: d_wr=1, d_addr=0x40, d_wdata=0x12345678. Required: mem_we high 5 cycles, mem_oe 0, wdata stable; d_ack single pulse; d_rdata unchanged.
- Timeout: TIMEOUT=4, d_rd=1, mem_ready never asserts. Required: mem_oe high exactly 4 cycles; d_ack and err pulse together; d_rdata=0; next transaction proceeds normally.
- Reset mid-ISSUE: assert reset during the 2nd cycle of mem_oe. Required: mem_oe/busy drop without a clock edge; no ack; after release, a tie grants D.
- Ready at timeout boundary: TIMEOUT=3, mem_ready on the 3rd ISSUE cycle with data 0xA5A5A5A5. Required: ack with rdata=0xA5A5A5A5, err=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single main-memory port between the instruction-fetch cache
// (I side, read only) and the data cache (D side, read or write). Only one
// memory transaction is in flight at a time. When both sides request in the
// same IDLE cycle, the side that was not granted last wins (round robin). A
// per-transaction timeout ends a transaction whose memory never answers and
// flags it with err.
//
// Transaction flow: IDLE (grant and latch) -> ISSUE (strobe held until
// mem_ready or timeout) -> RESP (one-cycle ack to the granted side) -> IDLE.
// Every output is a register.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high; clears all state immediately
//   i_rd      I-side read request, held until i_ack
//   i_addr    I-side address
//   i_ack     one-cycle completion pulse to the I side
//   i_rdata   I-side read data, valid with i_ack, held between acks
//   d_rd      D-side read request, held until d_ack
//   d_wr      D-side write request, held until d_ack (wins over d_rd)
//   d_addr    D-side address
//   d_wdata   D-side write data
//   d_ack     one-cycle completion pulse to the D side
//   d_rdata   D-side read data, valid with d_ack, held between acks
//   mem_oe    memory read strobe
//   mem_we    memory write strobe
//   mem_addr  memory address, constant during ISSUE
//   mem_wdata memory write data, constant during ISSUE
//   mem_rdata memory read data, valid with mem_ready
//   mem_ready memory completion, sampled only in ISSUE
//   busy      high whenever the arbiter is not IDLE
//   err       one-cycle pulse alongside the ack of a timed-out transaction
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    // A TIMEOUT of 0 disables the timeout; the compare value is then unused.
    localparam logic             TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    logic [1:0]       state;
    logic             last_grant;   // side granted most recently
    logic             grant;        // side owning the current transaction
    logic [CNT_W-1:0] cnt;          // ISSUE cycles elapsed without mem_ready

    logic d_pend;
    logic i_pend;
    logic grant_d;
    logic grant_wr;
    logic timeout_hit;

    // Round robin: a lone requester always wins; on a tie the side that was
    // not granted last wins.
    function automatic logic pick_d(input logic dp, input logic ip, input logic last);
        return dp && (!ip || (last == SIDE_I));
    endfunction

    assign d_pend      = d_rd | d_wr;
    assign i_pend      = i_rd;
    assign grant_d     = pick_d(d_pend, i_pend, last_grant);
    // d_rd together with d_wr is a write.
    assign grant_wr    = grant_d & d_wr;
    assign timeout_hit = TO_EN && (cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= SIDE_I;
            grant      <= SIDE_I;
            cnt        <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (d_pend || i_pend) begin
                        grant      <= grant_d;
                        last_grant <= grant_d;
                        mem_addr   <= grant_d ? d_addr : i_addr;
                        if (grant_d) begin
                            mem_wdata <= d_wdata;
                        end
                        mem_oe     <= ~grant_wr;
                        mem_we     <= grant_wr;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // Ready is checked first so that a response arriving on
                    // the last allowed cycle completes normally.
                    if (mem_ready) begin
                        if (!mem_we) begin
                            if (grant == SIDE_D) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                i_rdata <= mem_rdata;
                            end
                        end
                        mem_oe <= 1'b0;
                        mem_we <= 1'b0;
                        i_ack  <= (grant == SIDE_I);
                        d_ack  <= (grant == SIDE_D);
                        state  <= S_RESP;
                    end else if (timeout_hit) begin
                        // A hung transaction returns zero data to its owner.
                        if (grant == SIDE_D) begin
                            d_rdata <= '0;
                        end else begin
                            i_rdata <= '0;
                        end
                        mem_oe <= 1'b0;
                        mem_we <= 1'b0;
                        i_ack  <= (grant == SIDE_I);
                        d_ack  <= (grant == SIDE_D);
                        err    <= 1'b1;
                        state  <= S_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    // Requests are not sampled here: the requester drops its
                    // request during this ack cycle.
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    i_ack  <= 1'b0;
                    d_ack  <= 1'b0;
                    err    <= 1'b0;
                    mem_oe <= 1'b0;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two arbiters: instance 0 with TIMEOUT=255 (normal traffic, long write,
// round robin, reset mid-ISSUE) and instance 1 with TIMEOUT=4 (timeout and
// ready on the last allowed cycle). The stimulus pushes every expected ack
// into a scoreboard queue; a monitor pops and compares whenever an ack
// appears. A memory model per instance answers after a set number of strobe
// cycles and returns addr + 0x1000_0000 unless a fixed word is selected.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_rd      [2];
    logic [31:0] i_addr    [2];
    logic        i_ack     [2];
    logic [31:0] i_rdata   [2];
    logic        d_rd      [2];
    logic        d_wr      [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_ack     [2];
    logic [31:0] d_rdata   [2];
    logic        mem_oe    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        mem_ready [2] = '{1'b0, 1'b0};
    logic        busy      [2];
    logic        err       [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .ADDR_W (32),
            .DATA_W (32),
            .TIMEOUT(g == 0 ? 255 : 4),
            .CNT_W  (8)
        ) u_dut (
            .clk      (clk),
            .reset    (rst),
            .i_rd     (i_rd[g]),
            .i_addr   (i_addr[g]),
            .i_ack    (i_ack[g]),
            .i_rdata  (i_rdata[g]),
            .d_rd     (d_rd[g]),
            .d_wr     (d_wr[g]),
            .d_addr   (d_addr[g]),
            .d_wdata  (d_wdata[g]),
            .d_ack    (d_ack[g]),
            .d_rdata  (d_rdata[g]),
            .mem_oe   (mem_oe[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .mem_ready(mem_ready[g]),
            .busy     (busy[g]),
            .err      (err[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic        mem_fix;
    logic [31:0] mem_data;
    int          lat        [2];
    int          scnt       [2] = '{0, 0};
    int          oe_cnt     [2] = '{0, 0};
    int          we_cnt     [2] = '{0, 0};
    int          busy_cnt   [2] = '{0, 0};
    int          unstable   [2] = '{0, 0};
    logic [31:0] first_addr [2] = '{32'h0, 32'h0};
    logic [31:0] first_wdata[2] = '{32'h0, 32'h0};

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            mem_rdata[k] = mem_fix ? mem_data : (mem_addr[k] + 32'h1000_0000);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (busy[k]) busy_cnt[k]++;
            if (mem_oe[k] || mem_we[k]) begin
                scnt[k]++;
                if (mem_oe[k]) oe_cnt[k]++;
                if (mem_we[k]) we_cnt[k]++;
                if (scnt[k] == 1) begin
                    first_addr[k]  = mem_addr[k];
                    first_wdata[k] = mem_wdata[k];
                end else if (mem_addr[k] !== first_addr[k] || mem_wdata[k] !== first_wdata[k]) begin
                    unstable[k]++;
                end
                mem_ready[k] = (lat[k] != 0) && (scnt[k] == lat[k]);
            end else begin
                scnt[k]      = 0;
                mem_ready[k] = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          dut;
        bit          side_d;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    task automatic expect_ack(input int k, input bit side_d, input logic [31:0] rdata,
                              input bit e, input int at);
        exp_t x;
        x.dut = k; x.side_d = side_d; x.rdata = rdata; x.err = e; x.cyc = at;
        sb.push_back(x);
    endtask

    task automatic sb_check(input int k, input bit side_d);
        exp_t x;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ack: dut %0d side_d %0d at cycle %0d, required none", k, side_d, cyc);
        end else begin
            x = sb.pop_front();
            chk("ack_dut_side", {30'b0, k[0], side_d}, {30'b0, x.dut[0], x.side_d});
            chk("ack_rdata", side_d ? d_rdata[k] : i_rdata[k], x.rdata);
            chk("ack_err", {31'b0, err[k]}, {31'b0, x.err});
            chk("ack_cycle", 32'(cyc), 32'(x.cyc));
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("err_without_ack", {31'b0, err[k] & ~(i_ack[k] | d_ack[k])}, 32'h0);
            if (i_ack[k]) sb_check(k, 1'b0);
            if (d_ack[k]) sb_check(k, 1'b1);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Waits for the wanted acks, dropping each request in its ack cycle, then
    // lets RESP return to IDLE so the next request is sampled on the next edge.
    task automatic wait_acks(input int k, input bit want_i, input bit want_d,
                             input int maxc, input string name);
        bit gi;
        bit gd;
        gi = !want_i;
        gd = !want_d;
        for (int c = 0; c < maxc && !(gi && gd); c++) begin
            @(negedge clk);
            if (i_ack[k]) begin gi = 1'b1; i_rd[k] = 1'b0; end
            if (d_ack[k]) begin gd = 1'b1; d_rd[k] = 1'b0; d_wr[k] = 1'b0; end
        end
        chk({name, "_completed"}, {31'b0, gi && gd}, 32'h1);
        i_rd[k] = 1'b0; d_rd[k] = 1'b0; d_wr[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int r;
        int o0, w0, b0, u0;

        rst = 1'b1;
        mem_fix = 1'b0;
        mem_data = 32'h0;
        lat[0] = 1; lat[1] = 1;
        for (int k = 0; k < 2; k++) begin
            i_rd[k] = 0; d_rd[k] = 0; d_wr[k] = 0;
            i_addr[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_mem_oe", {31'b0, mem_oe[k]}, 32'h0);
            chk("rst_mem_we", {31'b0, mem_we[k]}, 32'h0);
            chk("rst_busy", {31'b0, busy[k]}, 32'h0);
            chk("rst_acks", {30'b0, i_ack[k], d_ack[k]}, 32'h0);
            chk("rst_mem_addr", mem_addr[k], 32'h0);
            chk("rst_d_rdata", d_rdata[k], 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single I read, memory ready on the first ISSUE cycle.
        mem_fix = 1'b1; mem_data = 32'hDEADBEEF; lat[0] = 1;
        o0 = oe_cnt[0]; w0 = we_cnt[0]; b0 = busy_cnt[0];
        r = cyc + 1;
        expect_ack(0, 1'b0, 32'hDEADBEEF, 1'b0, r + 1);
        i_addr[0] = 32'h100; i_rd[0] = 1'b1;
        wait_acks(0, 1'b1, 1'b0, 20, "t1");
        chk("t1_oe_cycles", 32'(oe_cnt[0] - o0), 32'd1);
        chk("t1_we_cycles", 32'(we_cnt[0] - w0), 32'd0);
        chk("t1_busy_cycles", 32'(busy_cnt[0] - b0), 32'd2);
        chk("t1_mem_addr", first_addr[0], 32'h100);
        mem_fix = 1'b0;

        // Tie after reset: D first, I three cycles later.
        do_reset();
        r = cyc + 1;
        expect_ack(0, 1'b1, 32'h1000_0020, 1'b0, r + 1);
        expect_ack(0, 1'b0, 32'h1000_0010, 1'b0, r + 4);
        i_addr[0] = 32'h10; d_addr[0] = 32'h20; i_rd[0] = 1'b1; d_rd[0] = 1'b1;
        wait_acks(0, 1'b1, 1'b1, 20, "t2a");

        // Last grant was I, so the next tie goes to D again.
        r = cyc + 1;
        expect_ack(0, 1'b1, 32'h1000_0034, 1'b0, r + 1);
        expect_ack(0, 1'b0, 32'h1000_0030, 1'b0, r + 4);
        i_addr[0] = 32'h30; d_addr[0] = 32'h34; i_rd[0] = 1'b1; d_rd[0] = 1'b1;
        wait_acks(0, 1'b1, 1'b1, 20, "t2b");

        // Lone D, then a tie: I wins.
        r = cyc + 1;
        expect_ack(0, 1'b1, 32'h1000_0050, 1'b0, r + 1);
        d_addr[0] = 32'h50; d_rd[0] = 1'b1;
        wait_acks(0, 1'b0, 1'b1, 20, "t2c");
        r = cyc + 1;
        expect_ack(0, 1'b0, 32'h1000_0060, 1'b0, r + 1);
        expect_ack(0, 1'b1, 32'h1000_0064, 1'b0, r + 4);
        i_addr[0] = 32'h60; d_addr[0] = 32'h64; i_rd[0] = 1'b1; d_rd[0] = 1'b1;
        wait_acks(0, 1'b1, 1'b1, 20, "t2d");

        // D write, 5-cycle memory: d_rdata keeps the last read value.
        lat[0] = 5;
        o0 = oe_cnt[0]; w0 = we_cnt[0]; u0 = unstable[0];
        r = cyc + 1;
        expect_ack(0, 1'b1, 32'h1000_0064, 1'b0, r + 5);
        d_addr[0] = 32'h40; d_wdata[0] = 32'h12345678; d_wr[0] = 1'b1;
        wait_acks(0, 1'b0, 1'b1, 30, "t3");
        chk("t3_we_cycles", 32'(we_cnt[0] - w0), 32'd5);
        chk("t3_oe_cycles", 32'(oe_cnt[0] - o0), 32'd0);
        chk("t3_stable", 32'(unstable[0] - u0), 32'd0);
        chk("t3_mem_addr", first_addr[0], 32'h40);
        chk("t3_mem_wdata", first_wdata[0], 32'h12345678);

        // d_rd and d_wr together behave as a write.
        lat[0] = 1;
        o0 = oe_cnt[0]; w0 = we_cnt[0];
        r = cyc + 1;
        expect_ack(0, 1'b1, 32'h1000_0064, 1'b0, r + 1);
        d_addr[0] = 32'h44; d_wdata[0] = 32'hCAFEF00D; d_rd[0] = 1'b1; d_wr[0] = 1'b1;
        wait_acks(0, 1'b0, 1'b1, 20, "t3b");
        chk("t3b_we_cycles", 32'(we_cnt[0] - w0), 32'd1);
        chk("t3b_oe_cycles", 32'(oe_cnt[0] - o0), 32'd0);
        chk("t3b_mem_wdata", first_wdata[0], 32'hCAFEF00D);

        // Instance 1 (TIMEOUT=4): a normal read, a timeout, then recovery.
        lat[1] = 2;
        r = cyc + 1;
        expect_ack(1, 1'b1, 32'h1000_0070, 1'b0, r + 2);
        d_addr[1] = 32'h70; d_rd[1] = 1'b1;
        wait_acks(1, 1'b0, 1'b1, 20, "t4a");

        lat[1] = 0;
        o0 = oe_cnt[1];
        r = cyc + 1;
        expect_ack(1, 1'b1, 32'h0, 1'b1, r + 4);
        d_addr[1] = 32'h80; d_rd[1] = 1'b1;
        wait_acks(1, 1'b0, 1'b1, 20, "t4b");
        chk("t4_oe_cycles", 32'(oe_cnt[1] - o0), 32'd4);

        lat[1] = 1;
        r = cyc + 1;
        expect_ack(1, 1'b0, 32'h1000_0090, 1'b0, r + 1);
        i_addr[1] = 32'h90; i_rd[1] = 1'b1;
        wait_acks(1, 1'b1, 1'b0, 20, "t4c");

        // Ready on the last allowed ISSUE cycle: completes without err.
        mem_fix = 1'b1; mem_data = 32'hA5A5A5A5; lat[1] = 4;
        o0 = oe_cnt[1];
        r = cyc + 1;
        expect_ack(1, 1'b0, 32'hA5A5A5A5, 1'b0, r + 4);
        i_addr[1] = 32'hA0; i_rd[1] = 1'b1;
        wait_acks(1, 1'b1, 1'b0, 20, "t5");
        chk("t5_oe_cycles", 32'(oe_cnt[1] - o0), 32'd4);
        mem_fix = 1'b0;

        // Reset during the second mem_oe cycle: no ack, last grant back to I.
        lat[0] = 0;
        d_addr[0] = 32'hC0; d_rd[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t6_oe_before_reset", {31'b0, mem_oe[0]}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_oe_async_drop", {31'b0, mem_oe[0]}, 32'h0);
        chk("t6_busy_async_drop", {31'b0, busy[0]}, 32'h0);
        chk("t6_no_ack", {30'b0, i_ack[0], d_ack[0]}, 32'h0);
        d_rd[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lat[0] = 1;
        r = cyc + 1;
        expect_ack(0, 1'b1, 32'h1000_00E0, 1'b0, r + 1);
        expect_ack(0, 1'b0, 32'h1000_00D0, 1'b0, r + 4);
        i_addr[0] = 32'hD0; d_addr[0] = 32'hE0; i_rd[0] = 1'b1; d_rd[0] = 1'b1;
        wait_acks(0, 1'b1, 1'b1, 20, "t6");

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
